kernel_ctrl_csr: RTL and testbench

Sub-CSR block sitting directly downstream of the CSR arbiter on one `sub_csr_if` port. It decodes MMIO reads and writes into a kernel-argument register file, a control register and a status register, and drives the start/done handshake with one compute kernel. It measures the cycle count of each kernel run. MMIO read responses go back to the arbiter one cycle after the request.

---
 rtl/kernel_csr_pkg.sv | 58 +++++
 rtl/sub_csr_if.sv | 14 +
 rtl/kernel_ctrl_fsm.sv | 85 ++++++++
 rtl/kernel_ctrl_csr.sv | 127 ++++++++++++
 tb/tb_kernel_ctrl_csr.sv | 223 ++++++++++++++++++++++
 5 files changed

// File: rtl/kernel_csr_pkg.sv
// rtl/kernel_csr_pkg.sv - shared constants, types and helpers for the kernel control CSR block
//
// Contents:
//   OFF_*          register offsets (dwords) relative to the block base address
//   STAT_*/CTRL_*  bit positions inside STATUS and CTRL
//   t_kernel_state FSM state encoding
//   t_csr_rx/tx    MMIO request / read-response bundles carried by sub_csr_if
//   sat_inc64      saturating 64-bit increment
package kernel_csr_pkg;

  localparam logic [15:0] OFF_CTRL     = 16'h0000;
  localparam logic [15:0] OFF_STATUS   = 16'h0002;
  localparam logic [15:0] OFF_CYCLES   = 16'h0004;
  localparam logic [15:0] OFF_ARG_BASE = 16'h0008;

  localparam int STAT_BUSY  = 0;
  localparam int STAT_DONE  = 1;
  localparam int STAT_ERROR = 2;
  localparam int CTRL_START = 0;
  localparam int CTRL_CLEAR = 1;

  // hdr.length encoding for an 8-byte MMIO access
  localparam logic [1:0] MMIO_LEN_8B = 2'b01;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_LAUNCH = 2'd1,
    ST_RUN    = 2'd2
  } t_kernel_state;

  typedef struct packed {
    logic [15:0] address;
    logic [1:0]  length;
    logic [8:0]  tid;
  } t_mmio_req_hdr;

  typedef struct packed {
    logic [8:0] tid;
  } t_mmio_rsp_hdr;

  typedef struct packed {
    t_mmio_req_hdr hdr;
    logic [63:0]   data;
    logic          rdValid;
    logic          wrValid;
  } t_csr_rx;

  typedef struct packed {
    t_mmio_rsp_hdr hdr;
    logic [63:0]   data;
    logic          mmioRdValid;
  } t_csr_tx;

  function automatic logic [63:0] sat_inc64(input logic [63:0] v);
    return (&v) ? v : v + 64'd1;
  endfunction

endpackage

// File: rtl/sub_csr_if.sv
// rtl/sub_csr_if.sv - one arbiter-to-sub-CSR MMIO port
//
// Signals:
//   rx  MMIO request (hdr, data, rdValid, wrValid), arbiter -> block
//   tx  read response (mmioRdValid, hdr.tid, data), block -> arbiter
interface sub_csr_if;
  import kernel_csr_pkg::*;

  t_csr_rx rx;
  t_csr_tx tx;

  modport to_afu     (input rx, output tx);
  modport to_arbiter (output rx, input tx);
endinterface

// File: rtl/kernel_ctrl_fsm.sv
// rtl/kernel_ctrl_fsm.sv - kernel launch FSM, run-cycle counter and sticky done/error flags
//
// Ports:
//   clk, reset       clock, synchronous active-high reset
//   i_start          CTRL write with start bit set (one cycle)
//   i_clear          CTRL write with clear bit set (one cycle)
//   i_kernel_done    completion pulse from the kernel
//   o_busy           state != IDLE
//   o_done, o_error  sticky status flags
//   o_cycles         cycle count of the last completed run
//   o_kernel_start   one-cycle launch pulse (high while in LAUNCH)
module kernel_ctrl_fsm
  import kernel_csr_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        i_start,
  input  logic        i_clear,
  input  logic        i_kernel_done,
  output logic        o_busy,
  output logic        o_done,
  output logic        o_error,
  output logic [63:0] o_cycles,
  output logic        o_kernel_start
);

  t_kernel_state r_state;
  logic          r_done;
  logic          r_error;
  logic [63:0]   r_counter;
  logic [63:0]   r_cycles;
  logic          r_kernel_start;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state        <= ST_IDLE;
      r_done         <= 1'b0;
      r_error        <= 1'b0;
      r_counter      <= '0;
      r_cycles       <= '0;
      r_kernel_start <= 1'b0;
    end else begin
      r_kernel_start <= 1'b0;
      // Clear is applied first so that a done/error set later in this
      // block takes precedence on the same edge.
      if (i_clear) begin
        r_done  <= 1'b0;
        r_error <= 1'b0;
      end
      case (r_state)
        ST_IDLE: begin
          if (i_start) begin
            r_state        <= ST_LAUNCH;
            r_kernel_start <= 1'b1;
            r_counter      <= '0;
          end
        end
        ST_LAUNCH: begin
          r_state   <= ST_RUN;
          r_counter <= sat_inc64(r_counter);
          if (i_start) r_error <= 1'b1;
        end
        ST_RUN: begin
          r_counter <= sat_inc64(r_counter);
          if (i_start) r_error <= 1'b1;
          if (i_kernel_done) begin
            r_state  <= ST_IDLE;
            r_done   <= 1'b1;
            // The done cycle itself is part of the run, so capture the
            // incremented value: LAUNCH through the done cycle inclusive.
            r_cycles <= sat_inc64(r_counter);
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign o_busy         = (r_state != ST_IDLE);
  assign o_done         = r_done;
  assign o_error        = r_error;
  assign o_cycles       = r_cycles;
  assign o_kernel_start = r_kernel_start;

endmodule

// File: rtl/kernel_ctrl_csr.sv
// rtl/kernel_ctrl_csr.sv - MMIO decode, argument registers and read mux for one compute kernel
//
// Ports:
//   clk, reset     clock, synchronous active-high reset
//   port           sub_csr_if.to_afu: MMIO request in, read response out (1-cycle latency)
//   kernel_start   one-cycle launch pulse
//   kernel_args    NUM_ARGS x 64-bit argument registers, ARG0 in the LSBs
//   kernel_done    one-cycle completion pulse from the kernel
module kernel_ctrl_csr
  import kernel_csr_pkg::*;
#(
  parameter logic [15:0] CSR_BASE = 16'h0010,
  parameter int          NUM_ARGS = 8
) (
  input  logic                    clk,
  input  logic                    reset,
  sub_csr_if.to_afu               port,
  output logic                    kernel_start,
  output logic [64*NUM_ARGS-1:0]  kernel_args,
  input  logic                    kernel_done
);

  logic [63:0] r_args [NUM_ARGS];
  logic        r_rd_valid;
  logic [8:0]  r_rd_tid;
  logic [63:0] r_rd_data;

  logic [15:0] w_offset;
  logic [15:0] w_arg_off;
  logic [3:0]  w_arg_idx;
  logic        w_in_range;
  logic        w_arg_hit;
  logic        w_wr_en;
  logic        w_ctrl_wr;
  logic        w_start;
  logic        w_clear;
  logic        w_busy;
  logic        w_done;
  logic        w_error;
  logic [63:0] w_cycles;
  logic [63:0] w_status;
  logic [63:0] w_rd_data;
  t_csr_tx     w_tx;

  // Address decode; the offset wraps below the base, so w_in_range gates it.
  assign w_in_range = (port.rx.hdr.address >= CSR_BASE);
  assign w_offset   = port.rx.hdr.address - CSR_BASE;
  assign w_arg_off  = w_offset - OFF_ARG_BASE;
  assign w_arg_idx  = w_arg_off[4:1];
  assign w_arg_hit  = w_in_range && (w_offset >= OFF_ARG_BASE) &&
                      (w_arg_off < 16'(2 * NUM_ARGS)) && !w_arg_off[0];

  assign w_wr_en   = port.rx.wrValid && (port.rx.hdr.length == MMIO_LEN_8B);
  assign w_ctrl_wr = w_wr_en && w_in_range && (w_offset == OFF_CTRL);
  assign w_start   = w_ctrl_wr && port.rx.data[CTRL_START];
  assign w_clear   = w_ctrl_wr && port.rx.data[CTRL_CLEAR];

  kernel_ctrl_fsm u_fsm (
    .clk            (clk),
    .reset          (reset),
    .i_start        (w_start),
    .i_clear        (w_clear),
    .i_kernel_done  (kernel_done),
    .o_busy         (w_busy),
    .o_done         (w_done),
    .o_error        (w_error),
    .o_cycles       (w_cycles),
    .o_kernel_start (kernel_start)
  );

  // Argument registers are frozen while a run is in flight.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < NUM_ARGS; i++) r_args[i] <= '0;
    end else if (w_wr_en && w_arg_hit && !w_busy) begin
      for (int i = 0; i < NUM_ARGS; i++) begin
        if (w_arg_idx == 4'(i)) r_args[i] <= port.rx.data;
      end
    end
  end

  always_comb begin
    kernel_args = '0;
    for (int i = 0; i < NUM_ARGS; i++) kernel_args[i*64 +: 64] = r_args[i];
  end

  always_comb begin
    w_status             = '0;
    w_status[STAT_BUSY]  = w_busy;
    w_status[STAT_DONE]  = w_done;
    w_status[STAT_ERROR] = w_error;
  end

  // CTRL, odd and unmapped addresses all fall through to zero.
  always_comb begin
    w_rd_data = '0;
    if (w_in_range && (w_offset == OFF_STATUS)) begin
      w_rd_data = w_status;
    end else if (w_in_range && (w_offset == OFF_CYCLES)) begin
      w_rd_data = w_cycles;
    end else begin
      for (int i = 0; i < NUM_ARGS; i++) begin
        if (w_arg_hit && (w_arg_idx == 4'(i))) w_rd_data = r_args[i];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_rd_valid <= 1'b0;
    end else begin
      r_rd_valid <= port.rx.rdValid;
    end
    r_rd_tid  <= port.rx.hdr.tid;
    r_rd_data <= w_rd_data;
  end

  always_comb begin
    w_tx             = '0;
    w_tx.mmioRdValid = r_rd_valid;
    w_tx.hdr.tid     = r_rd_tid;
    w_tx.data        = r_rd_data;
  end

  assign port.tx = w_tx;

endmodule

// File: tb/tb_kernel_ctrl_csr.sv
// tb/tb_kernel_ctrl_csr.sv - directed self-checking bench for kernel_ctrl_csr
module tb_kernel_ctrl_csr;
  import kernel_csr_pkg::*;

  localparam logic [15:0] A_CTRL   = 16'h0010;
  localparam logic [15:0] A_STATUS = 16'h0012;
  localparam logic [15:0] A_CYCLES = 16'h0014;
  localparam logic [15:0] A_ARG0   = 16'h0018;
  localparam logic [15:0] A_ARG1   = 16'h001A;
  localparam logic [15:0] A_ARG7   = 16'h0026;
  localparam logic [63:0] ARG0_VAL = 64'hDEAD_BEEF_0000_0001;

  logic         clk = 1'b0;
  logic         reset;
  logic         kernel_start;
  logic         kernel_done;
  logic [511:0] kernel_args;

  int n_cmp = 0;
  int n_fail = 0;
  int start_pulses = 0;

  sub_csr_if csr();

  kernel_ctrl_csr #(.CSR_BASE(16'h0010), .NUM_ARGS(8)) dut (
    .clk          (clk),
    .reset        (reset),
    .port         (csr),
    .kernel_start (kernel_start),
    .kernel_args  (kernel_args),
    .kernel_done  (kernel_done)
  );

  always #5 clk = ~clk;

  always @(negedge clk) if (kernel_start === 1'b1) start_pulses++;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic mmio_write(input logic [15:0] a, input logic [1:0] len, input logic [63:0] d);
    csr.rx.hdr.address = a;
    csr.rx.hdr.length  = len;
    csr.rx.hdr.tid     = 9'h0;
    csr.rx.data        = d;
    csr.rx.wrValid     = 1'b1;
    tick();
    csr.rx.wrValid     = 1'b0;
  endtask

  task automatic mmio_read(input logic [15:0] a, input logic [8:0] tid,
                           output logic [63:0] d, output logic v, output logic [8:0] t);
    csr.rx.hdr.address = a;
    csr.rx.hdr.length  = MMIO_LEN_8B;
    csr.rx.hdr.tid     = tid;
    csr.rx.rdValid     = 1'b1;
    tick();
    csr.rx.rdValid     = 1'b0;
    v = csr.tx.mmioRdValid;
    t = csr.tx.hdr.tid;
    d = csr.tx.data;
  endtask

  task automatic test_reset();
    logic [63:0] d; logic v; logic [8:0] t;
    reset = 1'b1; kernel_done = 1'b0; csr.rx = '0;
    repeat (3) tick();
    n_cmp++; if (csr.tx.mmioRdValid !== 1'b0) begin n_fail++; $display("FAIL reset_rdvalid got=%0b exp=0", csr.tx.mmioRdValid); end
    n_cmp++; if (kernel_start !== 1'b0) begin n_fail++; $display("FAIL reset_kstart got=%0b exp=0", kernel_start); end
    n_cmp++; if (kernel_args !== '0) begin n_fail++; $display("FAIL reset_args got=%h exp=0", kernel_args[63:0]); end
    reset = 1'b0;
    tick();
    mmio_read(A_STATUS, 9'h001, d, v, t);
    n_cmp++; if (d !== 64'h0) begin n_fail++; $display("FAIL reset_status got=%h exp=0", d); end
    mmio_read(A_CYCLES, 9'h002, d, v, t);
    n_cmp++; if (d !== 64'h0) begin n_fail++; $display("FAIL reset_cycles got=%h exp=0", d); end
  endtask

  task automatic test_args();
    logic [63:0] d; logic v; logic [8:0] t;
    mmio_write(A_ARG0, MMIO_LEN_8B, ARG0_VAL);
    mmio_write(A_ARG7, MMIO_LEN_8B, 64'h7);
    csr.rx.hdr.address = A_ARG0; csr.rx.hdr.length = MMIO_LEN_8B; csr.rx.hdr.tid = 9'h0A5; csr.rx.rdValid = 1'b1;
    #1;
    n_cmp++; if (csr.tx.mmioRdValid !== 1'b0) begin n_fail++; $display("FAIL args_rdvalid_early got=%0b exp=0", csr.tx.mmioRdValid); end
    tick();
    csr.rx.rdValid = 1'b0;
    n_cmp++; if (csr.tx.mmioRdValid !== 1'b1) begin n_fail++; $display("FAIL args_rdvalid got=%0b exp=1", csr.tx.mmioRdValid); end
    n_cmp++; if (csr.tx.hdr.tid !== 9'h0A5) begin n_fail++; $display("FAIL args_tid got=%h exp=0a5", csr.tx.hdr.tid); end
    n_cmp++; if (csr.tx.data !== ARG0_VAL) begin n_fail++; $display("FAIL args_arg0 got=%h exp=%h", csr.tx.data, ARG0_VAL); end
    tick();
    n_cmp++; if (csr.tx.mmioRdValid !== 1'b0) begin n_fail++; $display("FAIL args_rdvalid_late got=%0b exp=0", csr.tx.mmioRdValid); end
    mmio_read(A_ARG7, 9'h113, d, v, t);
    n_cmp++; if (d !== 64'h7) begin n_fail++; $display("FAIL args_arg7 got=%h exp=7", d); end
    n_cmp++; if (t !== 9'h113) begin n_fail++; $display("FAIL args_tid7 got=%h exp=113", t); end
    n_cmp++; if (kernel_args[511:448] !== 64'h7 || kernel_args[63:0] !== ARG0_VAL) begin n_fail++; $display("FAIL args_out got=%h/%h exp=7/%h", kernel_args[511:448], kernel_args[63:0], ARG0_VAL); end
  endtask

  task automatic test_len_and_odd();
    logic [63:0] d; logic v; logic [8:0] t;
    mmio_write(A_ARG1, 2'b00, 64'h5);
    mmio_read(A_ARG1, 9'h004, d, v, t);
    n_cmp++; if (d !== 64'h0) begin n_fail++; $display("FAIL len4_arg1 got=%h exp=0", d); end
    mmio_read(16'h0013, 9'h005, d, v, t);
    n_cmp++; if (d !== 64'h0) begin n_fail++; $display("FAIL odd_read got=%h exp=0", d); end
    mmio_read(A_CTRL, 9'h006, d, v, t);
    n_cmp++; if (d !== 64'h0) begin n_fail++; $display("FAIL ctrl_read got=%h exp=0", d); end
  endtask

  task automatic test_run();
    logic [63:0] d; logic v; logic [8:0] t; int s0;
    s0 = start_pulses;
    mmio_write(A_CTRL, MMIO_LEN_8B, 64'h1);             // now in LAUNCH cycle L
    n_cmp++; if (kernel_start !== 1'b1) begin n_fail++; $display("FAIL run_kstart got=%0b exp=1", kernel_start); end
    tick();                                             // L+1
    n_cmp++; if (kernel_start !== 1'b0) begin n_fail++; $display("FAIL run_kstart_drop got=%0b exp=0", kernel_start); end
    mmio_read(A_STATUS, 9'h007, d, v, t);               // returns at L+2
    n_cmp++; if (d !== 64'h1) begin n_fail++; $display("FAIL run_status_busy got=%h exp=1", d); end
    repeat (8) tick();                                  // L+10
    kernel_done = 1'b1;
    tick();
    kernel_done = 1'b0;
    mmio_read(A_STATUS, 9'h008, d, v, t);
    n_cmp++; if (d !== 64'h2) begin n_fail++; $display("FAIL run_status_done got=%h exp=2", d); end
    mmio_read(A_CYCLES, 9'h009, d, v, t);
    n_cmp++; if (d !== 64'd11) begin n_fail++; $display("FAIL run_cycles got=%0d exp=11", d); end
    n_cmp++; if (start_pulses - s0 !== 1) begin n_fail++; $display("FAIL run_pulses got=%0d exp=1", start_pulses - s0); end
  endtask

  task automatic test_busy_writes();
    logic [63:0] d; logic v; logic [8:0] t; int s0;
    mmio_write(A_CTRL, MMIO_LEN_8B, 64'h2);
    s0 = start_pulses;
    mmio_write(A_CTRL, MMIO_LEN_8B, 64'h1);
    mmio_write(A_ARG0, MMIO_LEN_8B, 64'h55);
    mmio_write(A_CTRL, MMIO_LEN_8B, 64'h1);
    repeat (3) tick();
    n_cmp++; if (kernel_args[63:0] !== ARG0_VAL) begin n_fail++; $display("FAIL busy_args got=%h exp=%h", kernel_args[63:0], ARG0_VAL); end
    kernel_done = 1'b1;
    tick();
    kernel_done = 1'b0;
    mmio_read(A_STATUS, 9'h00A, d, v, t);
    n_cmp++; if (d !== 64'h6) begin n_fail++; $display("FAIL busy_status got=%h exp=6", d); end
    n_cmp++; if (start_pulses - s0 !== 1) begin n_fail++; $display("FAIL busy_pulses got=%0d exp=1", start_pulses - s0); end
    mmio_read(A_ARG0, 9'h00B, d, v, t);
    n_cmp++; if (d !== ARG0_VAL) begin n_fail++; $display("FAIL busy_arg0 got=%h exp=%h", d, ARG0_VAL); end
  endtask

  task automatic test_clear_race();
    logic [63:0] d; logic v; logic [8:0] t;
    mmio_write(A_CTRL, MMIO_LEN_8B, 64'h2);
    mmio_read(A_STATUS, 9'h00C, d, v, t);
    n_cmp++; if (d !== 64'h0) begin n_fail++; $display("FAIL clr_status got=%h exp=0", d); end
    mmio_write(A_CTRL, MMIO_LEN_8B, 64'h1);             // LAUNCH at L
    tick();                                             // L+1
    mmio_write(A_CTRL, MMIO_LEN_8B, 64'h1);             // sets error, returns L+2
    tick();                                             // L+3
    csr.rx.hdr.address = A_CTRL; csr.rx.hdr.length = MMIO_LEN_8B; csr.rx.data = 64'h2; csr.rx.wrValid = 1'b1;
    kernel_done = 1'b1;
    tick();
    csr.rx.wrValid = 1'b0; kernel_done = 1'b0;
    mmio_read(A_STATUS, 9'h00D, d, v, t);
    n_cmp++; if (d !== 64'h2) begin n_fail++; $display("FAIL race_status got=%h exp=2", d); end
    mmio_read(A_CYCLES, 9'h00E, d, v, t);
    n_cmp++; if (d !== 64'd4) begin n_fail++; $display("FAIL race_cycles got=%0d exp=4", d); end
    mmio_write(A_CTRL, MMIO_LEN_8B, 64'h2);
    mmio_read(A_STATUS, 9'h00F, d, v, t);
    n_cmp++; if (d !== 64'h0) begin n_fail++; $display("FAIL race_clear got=%h exp=0", d); end
  endtask

  task automatic test_start_clear();
    logic [63:0] d; logic v; logic [8:0] t;
    mmio_write(A_CTRL, MMIO_LEN_8B, 64'h1);
    tick();
    kernel_done = 1'b1;
    tick();
    kernel_done = 1'b0;
    mmio_write(A_CTRL, MMIO_LEN_8B, 64'h3);
    n_cmp++; if (kernel_start !== 1'b1) begin n_fail++; $display("FAIL sc_kstart got=%0b exp=1", kernel_start); end
    mmio_read(A_STATUS, 9'h010, d, v, t);
    n_cmp++; if (d !== 64'h1) begin n_fail++; $display("FAIL sc_status got=%h exp=1", d); end
    kernel_done = 1'b1;
    tick();
    kernel_done = 1'b0;
  endtask

  task automatic test_reset_midrun();
    logic [63:0] d; logic v; logic [8:0] t;
    mmio_write(A_CTRL, MMIO_LEN_8B, 64'h1);
    repeat (5) tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    n_cmp++; if (kernel_args !== '0) begin n_fail++; $display("FAIL rst_args got=%h exp=0", kernel_args[63:0]); end
    mmio_read(A_STATUS, 9'h011, d, v, t);
    n_cmp++; if (d !== 64'h0) begin n_fail++; $display("FAIL rst_status got=%h exp=0", d); end
    mmio_read(A_CYCLES, 9'h012, d, v, t);
    n_cmp++; if (d !== 64'h0) begin n_fail++; $display("FAIL rst_cycles got=%h exp=0", d); end
    kernel_done = 1'b1;
    tick();
    kernel_done = 1'b0;
    mmio_read(A_STATUS, 9'h014, d, v, t);
    n_cmp++; if (d !== 64'h0) begin n_fail++; $display("FAIL rst_done_ignored got=%h exp=0", d); end
    mmio_read(A_CYCLES, 9'h015, d, v, t);
    n_cmp++; if (d !== 64'h0) begin n_fail++; $display("FAIL rst_cycles_after got=%h exp=0", d); end
  endtask

  initial begin
    test_reset();
    test_args();
    test_len_and_odd();
    test_run();
    test_busy_writes();
    test_clear_race();
    test_start_clear();
    test_reset_midrun();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
